// File: rtl/uart_bus_frame_decoder.sv
// UART-to-bus bridge: 8N1 byte receiver feeding a frame decoder that turns
// header/address/data byte sequences into a single-entry bus request.
module uart_bus_frame_decoder #(
    parameter int unsigned ADDR_WIDTH            = 16,
    parameter int unsigned DATA_WIDTH            = 8,
    parameter int unsigned UART_CLOCKS_PER_PULSE = 5208,
    parameter int unsigned TIMEOUT_CLKS          = 83328
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_rx,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_wr,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned BIT_CNT_W = $clog2(UART_CLOCKS_PER_PULSE + 1);
    localparam int unsigned TO_CNT_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_HALF = BIT_CNT_W'(UART_CLOCKS_PER_PULSE / 2);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]           HDR_RD   = 8'hA0;
    localparam logic [7:0]           HDR_WR   = 8'hA1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        FR_HDR,
        FR_AHI,
        FR_ALO,
        FR_DAT,
        FR_OUT
    } fr_state_t;

    // ---------------- serial byte receiver ----------------
    logic                 r_sync1, r_sync2;
    logic [1:0]           r_warm;
    logic                 r_armed;
    rx_state_t            r_rx_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_byte_valid;
    logic                 r_bit_err;

    rx_state_t            w_rx_state_nxt;
    logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic [7:0]           w_shift_nxt;
    logic                 w_byte_valid_nxt;
    logic                 w_bit_err_nxt;
    logic                 w_armed_nxt;
    logic                 w_rx;

    assign w_rx = r_sync2;

    // Synchronizer; r_warm marks when r_sync2 reflects a real line sample,
    // so the reset value of the flops cannot arm the receiver.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_warm  <= 2'b00;
        end else begin
            r_sync1 <= u_rx;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_bit_err    <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_bit_err    <= w_bit_err_nxt;
            r_armed      <= w_armed_nxt;
        end
    end

    // Start bits are only accepted once the line has been seen idle high.
    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_bit_err_nxt    = 1'b0;
        w_armed_nxt      = r_armed | (r_warm[1] & w_rx);

        unique case (r_rx_state)
            RX_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (r_armed && !w_rx) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_bit_cnt == BIT_HALF) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_bit_cnt_nxt = BIT_CNT_W'(r_bit_cnt + 1'b1);
                end
            end
            RX_DATA: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {w_rx, r_shift[7:1]};
                    w_bit_idx_nxt = 3'(r_bit_idx + 3'd1);
                    if (r_bit_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end else begin
                    w_bit_cnt_nxt = BIT_CNT_W'(r_bit_cnt + 1'b1);
                end
            end
            RX_STOP: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_bit_cnt_nxt  = '0;
                    w_rx_state_nxt = RX_IDLE;
                    if (w_rx) begin
                        w_byte_valid_nxt = 1'b1;
                    end else begin
                        w_bit_err_nxt = 1'b1;
                        w_armed_nxt   = 1'b0;
                    end
                end else begin
                    w_bit_cnt_nxt = BIT_CNT_W'(r_bit_cnt + 1'b1);
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- frame decoder and request register ----------------
    fr_state_t             r_fr_state;
    logic [TO_CNT_W-1:0]   r_to_cnt;
    logic                  r_f_wr;
    logic [ADDR_WIDTH-1:0] r_f_addr;
    logic [DATA_WIDTH-1:0] r_f_wdata;
    logic                  r_req_valid;
    logic                  r_req_wr;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic                  r_frame_err;
    logic                  r_overrun;

    fr_state_t             w_fr_state_nxt;
    logic [TO_CNT_W-1:0]   w_to_cnt_nxt;
    logic                  w_f_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_f_addr_nxt;
    logic [DATA_WIDTH-1:0] w_f_wdata_nxt;
    logic                  w_req_valid_nxt;
    logic                  w_req_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_req_addr_nxt;
    logic [DATA_WIDTH-1:0] w_req_wdata_nxt;
    logic                  w_frame_err_nxt;
    logic                  w_overrun_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fr_state  <= FR_HDR;
            r_to_cnt    <= '0;
            r_f_wr      <= 1'b0;
            r_f_addr    <= '0;
            r_f_wdata   <= '0;
            r_req_valid <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_fr_state  <= w_fr_state_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_f_wr      <= w_f_wr_nxt;
            r_f_addr    <= w_f_addr_nxt;
            r_f_wdata   <= w_f_wdata_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_wr    <= w_req_wr_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_req_wdata <= w_req_wdata_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // A byte-level error anywhere aborts the frame; completion loads the
    // request unless one is still pending and not being accepted.
    always_comb begin
        w_fr_state_nxt  = r_fr_state;
        w_to_cnt_nxt    = '0;
        w_f_wr_nxt      = r_f_wr;
        w_f_addr_nxt    = r_f_addr;
        w_f_wdata_nxt   = r_f_wdata;
        w_req_valid_nxt = r_req_valid & ~req_ready;
        w_req_wr_nxt    = r_req_wr;
        w_req_addr_nxt  = r_req_addr;
        w_req_wdata_nxt = r_req_wdata;
        w_frame_err_nxt = r_bit_err;
        w_overrun_nxt   = 1'b0;

        unique case (r_fr_state)
            FR_HDR: begin
                if (r_byte_valid) begin
                    if (r_shift == HDR_RD || r_shift == HDR_WR) begin
                        w_f_wr_nxt     = (r_shift == HDR_WR);
                        w_f_wdata_nxt  = '0;
                        w_fr_state_nxt = FR_AHI;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            FR_AHI, FR_ALO, FR_DAT: begin
                if (r_bit_err) begin
                    w_fr_state_nxt = FR_HDR;
                end else if (r_byte_valid) begin
                    if (r_fr_state == FR_AHI) begin
                        w_f_addr_nxt[ADDR_WIDTH-1 -: 8] = r_shift;
                        w_fr_state_nxt = FR_ALO;
                    end else if (r_fr_state == FR_ALO) begin
                        w_f_addr_nxt[7:0] = r_shift;
                        w_fr_state_nxt = r_f_wr ? FR_DAT : FR_OUT;
                    end else begin
                        w_f_wdata_nxt  = DATA_WIDTH'(r_shift);
                        w_fr_state_nxt = FR_OUT;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_frame_err_nxt = 1'b1;
                    w_fr_state_nxt  = FR_HDR;
                end else begin
                    w_to_cnt_nxt = TO_CNT_W'(r_to_cnt + 1'b1);
                end
            end
            FR_OUT: begin
                w_fr_state_nxt = FR_HDR;
                if (!r_bit_err) begin
                    if (!r_req_valid || req_ready) begin
                        w_req_valid_nxt = 1'b1;
                        w_req_wr_nxt    = r_f_wr;
                        w_req_addr_nxt  = r_f_addr;
                        w_req_wdata_nxt = r_f_wdata;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                end
            end
            default: w_fr_state_nxt = FR_HDR;
        endcase
    end

    assign req_valid = r_req_valid;
    assign req_wr    = r_req_wr;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_bus_frame_decoder.sv
// Scoreboard bench for uart_bus_frame_decoder: frames are serialised onto
// u_rx, expected requests queued at send time and popped by a monitor.
module tb_uart_bus_frame_decoder;

    localparam int unsigned CPP = 4;
    localparam int unsigned TO  = 100;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        u_rx;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        frame_err;
    logic        overrun;

    uart_bus_frame_decoder #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .UART_CLOCKS_PER_PULSE(CPP),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .u_rx(u_rx),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    req_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ferr_seen = 0;
    int   ovr_seen  = 0;
    int   exp_ferr  = 0;
    int   exp_ovr   = 0;
    bit   rand_ready = 1'b0;
    bit   held_v    = 1'b0;
    req_t held;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: error pulse counting, hold-stability and scoreboard pop.
    always @(negedge clk) begin
        req_t cur;
        req_t e;
        cur = {req_wr, req_addr, req_wdata};
        if (!rstn) begin
            held_v = 1'b0;
        end else begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (frame_err || overrun)
                chk(!(frame_err && overrun), "err_ovr_exclusive", {frame_err, overrun}, 0);
            if (held_v)
                chk(req_valid && (cur == held), "req_hold", {req_valid, cur}, {1'b1, held});
            if (req_valid && req_ready) begin
                chk(exp_q.size() != 0, "unexpected_req", cur, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(cur == e, "req_payload", cur, e);
                end
                held_v = 1'b0;
            end else if (req_valid) begin
                held_v = 1'b1;
                held   = cur;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) req_ready = 1'($urandom_range(1, 0));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic line_bit(input logic v);
        u_rx = v;
        idle(CPP);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        u_rx = 1'b1;
    endtask

    task automatic send_frame(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                              input bit push, input int gap_max);
        if (push) exp_q.push_back({wr, addr, wr ? data : 8'h00});
        send_byte(wr ? 8'hA1 : 8'hA0, 1'b1);
        idle($urandom_range(gap_max, 0));
        send_byte(addr[15:8], 1'b1);
        idle($urandom_range(gap_max, 0));
        send_byte(addr[7:0], 1'b1);
        if (wr) begin
            idle($urandom_range(gap_max, 0));
            send_byte(data, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    task automatic check_counts(input string name);
        repeat (6) @(negedge clk);
        chk(ferr_seen == exp_ferr, {name, "_frame_err_count"}, ferr_seen, exp_ferr);
        chk(ovr_seen == exp_ovr, {name, "_overrun_count"}, ovr_seen, exp_ovr);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!req_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(req_valid, name, req_valid, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(req_valid == 1'b0, {name, "_valid"}, req_valid, 0);
        chk(req_wr == 1'b0, {name, "_wr"}, req_wr, 0);
        chk(req_addr == 16'h0, {name, "_addr"}, req_addr, 0);
        chk(req_wdata == 8'h0, {name, "_wdata"}, req_wdata, 0);
        chk(frame_err == 1'b0, {name, "_frame_err"}, frame_err, 0);
        chk(overrun == 1'b0, {name, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] a;
        rstn = 1'b0;
        u_rx = 1'b1;
        req_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(10);

        // Plain write with ready high
        req_ready = 1'b1;
        send_frame(1'b1, 16'h1234, 8'h5A, 1'b1, 0);
        drain("w1234_drain");
        check_counts("w1234");

        // Read held under backpressure, released one cycle after ready
        req_ready = 1'b0;
        send_frame(1'b0, 16'hBEEF, 8'h00, 1'b1, 0);
        wait_valid("beef_valid");
        repeat (20) @(negedge clk);
        chk(req_valid && req_addr == 16'hBEEF && !req_wr, "beef_held", {req_valid, req_addr}, {1'b1, 16'hBEEF});
        @(posedge clk);
        #1 req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(!req_valid, "beef_cleared", req_valid, 0);
        check_counts("beef");

        // Bad stop bit on the data byte, then a good read
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b0);
        exp_ferr++;
        idle(20);
        chk(exp_q.size() == 0 && !req_valid, "badstop_no_req", req_valid, 0);
        send_frame(1'b0, 16'h0002, 8'h00, 1'b1, 3);
        drain("badstop_drain");
        check_counts("badstop");

        // Bad header byte followed by a good read
        send_byte(8'h7E, 1'b1);
        exp_ferr++;
        send_frame(1'b0, 16'h1122, 8'h00, 1'b1, 3);
        drain("badhdr_drain");
        check_counts("badhdr");

        // Inter-byte timeout
        send_byte(8'hA0, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(150);
        exp_ferr++;
        check_counts("timeout");

        // Overrun: second frame completes while first is pending
        req_ready = 1'b0;
        send_frame(1'b0, 16'hAABB, 8'h00, 1'b1, 0);
        wait_valid("ovr_first_valid");
        send_frame(1'b0, 16'h4455, 8'h00, 1'b0, 0);
        exp_ovr++;
        idle(10);
        chk(req_valid && req_addr == 16'hAABB, "ovr_keeps_first", req_addr, 16'hAABB);
        req_ready = 1'b1;
        drain("ovr_drain");
        check_counts("overrun");

        // Line low while reset releases must not start a byte
        rstn = 1'b0;
        u_rx = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(20);
        u_rx = 1'b1;
        idle(10);
        send_frame(1'b0, 16'h5678, 8'h00, 1'b1, 2);
        drain("lowrel_drain");
        check_counts("lowrel");

        // Reset in the middle of the address-high byte
        send_byte(8'hA1, 1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b1);
        rstn = 1'b0;
        idle(3);
        u_rx = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(10);
        send_frame(1'b1, 16'h0FF0, 8'hC3, 1'b1, 0);
        drain("midreset_drain");
        check_counts("midreset");

        // One-cycle glitch is ignored silently
        u_rx = 1'b0;
        idle(1);
        u_rx = 1'b1;
        idle(40);
        chk(!req_valid, "glitch_no_req", req_valid, 0);
        check_counts("glitch");

        // Randomized frames with random ready and inter-byte gaps
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9, 0) == 0) begin
                b = 8'($urandom_range(255, 0));
                if (b == 8'hA0 || b == 8'hA1) b = 8'h55;
                send_byte(b, 1'b1);
                exp_ferr++;
            end else begin
                a = 16'($urandom_range(16'hFFFF, 0));
                b = 8'($urandom_range(255, 0));
                send_frame(1'($urandom_range(1, 0)), a, b, 1'b1, 20);
            end
            idle($urandom_range(30, 0));
        end
        rand_ready = 1'b0;
        req_ready = 1'b1;
        drain("random_drain");
        check_counts("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_frame_decoder.md
UART_BUS_FRAME_DECODER -- requirements
Module: uart_bus_frame_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, bus address width; fixed at 16 for frame format.
REQ-002 Parameter DATA_WIDTH, default 8, bus data width; fixed at 8.
REQ-003 Parameter UART_CLOCKS_PER_PULSE, default 5208, clk cycles per UART bit.
REQ-004 Parameter TIMEOUT_CLKS, default 83328, max idle clk cycles between bytes of one frame.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port rstn  input  1  reset, synchronous, active-low.
REQ-007 Port u_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-008 Port req_valid  output  1  decoded bus request available.
REQ-009 Port req_ready  input  1  downstream accepts request.
REQ-010 Port req_wr  output  1  1 = write, 0 = read.
REQ-011 Port req_addr  output  ADDR_WIDTH  request address.
REQ-012 Port req_wdata  output  DATA_WIDTH  write data; 0 for reads.
REQ-013 Port frame_err  output  1  one-cycle pulse: bad stop bit, bad header or timeout.
REQ-014 Port overrun  output  1  one-cycle pulse: complete frame dropped because a request was pending.

Function
REQ-015 u_rx SHALL pass a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-016 Bit RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE -> START on synchronized line low; START checks line at count UART_CLOCKS_PER_PULSE/2; low -> DATA, high -> IDLE (glitch, no error).
REQ-018 DATA SHALL sample one bit every UART_CLOCKS_PER_PULSE cycles, 8 bits LSB first, then -> STOP.
REQ-019 STOP samples after UART_CLOCKS_PER_PULSE cycles: high -> byte valid one cycle, -> IDLE; low -> frame_err pulse, frame discarded, -> IDLE once line is high.
REQ-020 Frame FSM states SHALL be HDR, AHI, ALO, DAT, OUT.
REQ-021 Header byte SHALL be 8'hA0 (read) or 8'hA1 (write); any other value -> frame_err pulse, stay HDR.
REQ-022 AHI captures addr[15:8], ALO captures addr[7:0]; after ALO, read -> OUT, write -> DAT; DAT captures wdata -> OUT.
REQ-023 OUT: outputs loaded, req_valid=1 the cycle after last byte's stop bit; frame FSM -> HDR same cycle.
REQ-024 req_valid, req_wr, req_addr, req_wdata SHALL hold stable until req_valid && req_ready; req_valid clears the following cycle.
REQ-025 Frame completing while req_valid=1 and req_ready=0 that cycle -> frame dropped, outputs unchanged, overrun pulse.
REQ-026 Frame completing in the same cycle as acceptance (req_valid && req_ready) SHALL load new request, req_valid stays 1, no overrun.
REQ-027 Bit RX SHALL keep receiving while req_valid=1 (no backpressure on serial line).
REQ-028 In AHI/ALO/DAT, inter-byte counter counts cycles since last valid byte; reaching TIMEOUT_CLKS -> frame_err pulse, frame FSM -> HDR; counter reset on every valid byte.
REQ-029 A bit-level error mid-frame SHALL also return frame FSM to HDR.
REQ-030 frame_err and overrun SHALL never both assert in one cycle; stop-bit error takes priority and cancels completion.

Reset
REQ-031 rstn=0 at a clock edge SHALL force: both FSMs to IDLE/HDR, counters 0, synchronizer flops 1, req_valid=0, req_wr=0, req_addr=0, req_wdata=0, frame_err=0, overrun=0.
REQ-032 Reset mid-byte or mid-frame SHALL discard partial data; first start bit after release is decoded normally.
REQ-033 If u_rx is low when rstn releases, receiver SHALL wait for line high before accepting a start bit.

Verification (UART_CLOCKS_PER_PULSE=4, TIMEOUT_CLKS=100)
REQ-034 Send A1,12,34,5A, req_ready=1 -> one req_valid cycle with wr=1, addr=16'h1234, wdata=8'h5A; no error pulses.
REQ-035 Send A0,BE,EF, req_ready=0 for 20 cycles -> req_valid held with wr=0, addr=16'hBEEF, wdata=0; cleared one cycle after req_ready=1.
REQ-036 Send A1,00,01,FF with stop bit of byte 3 forced 0 -> frame_err pulse, no req_valid; following A0,00,02 decodes addr=16'h0002.
REQ-037 Send 7E, then A0,11,22 -> frame_err pulse on 7E; req addr=16'h1122 follows.
REQ-038 Send A0,33 then idle 100 cycles -> frame_err pulse, no request; req_ready=0 with second frame A0,44,55 arriving while first pending -> overrun pulse, outputs keep first request.
REQ-039 Assert rstn=0 mid-byte of AHI, release, send A1,0F,F0,C3 -> single write addr=16'h0FF0, wdata=8'hC3.
